// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and write-port request type for the register file
package regfile_pkg;

    localparam int DEF_REG_WIDTH  = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);
    localparam int DEF_NUM_READ   = 4;
    localparam int DEF_NUM_WRITE  = 2;

    // One write-port request at the default geometry.
    typedef struct packed {
        logic                      en;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_REG_WIDTH-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve/clear and a running busy count
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_set_en        reserve request this cycle
//   i_set_addr      register to mark busy
//   i_clr_vec       one bit per register, set where a write commits this cycle
//   o_busy          busy bit per register
//   o_busy_count    number of busy registers (registered)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_set_en,
    input  logic [ADDR_WIDTH-1:0] i_set_addr,
    input  logic [NUM_REGS-1:0]   i_clr_vec,
    output logic [NUM_REGS-1:0]   o_busy,
    output logic [ADDR_WIDTH:0]   o_busy_count
);

    localparam int               CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]    C_ONE = CW'(1);

    logic [NUM_REGS-1:0] r_busy;
    logic [CW-1:0]       r_count;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CW-1:0]       w_dec;
    logic                w_inc;

    // Set is applied after clear so a same-cycle reserve and write leaves the bit busy.
    always_comb begin
        w_set_vec = '0;
        if (i_set_en) begin
            w_set_vec[i_set_addr] = 1'b1;
        end
        w_busy_nxt = (r_busy & ~i_clr_vec) | w_set_vec;
        w_inc      = i_set_en && !r_busy[i_set_addr];
        w_dec      = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r_busy[r] && !w_busy_nxt[r]) begin
                w_dec = w_dec + C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= r_count + (w_inc ? C_ONE : '0) - w_dec;
        end
    end

    assign o_busy       = r_busy;
    assign o_busy_count = r_count;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiported register file with busy scoreboard
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   write_enable    per-port write strobe (NUM_WRITE)
//   write_addr      packed write addresses, port p at slice p
//   write_data      packed write data, port p at slice p
//   read_addr       packed read addresses (NUM_READ)
//   read_data       packed combinational read data
//   read_busy       busy bit of each read address
//   reserve_valid   mark reserve_addr busy at the next edge
//   reserve_addr    register to reserve
//   busy_count      number of busy registers
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH       = DEF_REG_WIDTH,
    parameter int NUM_REGS        = DEF_NUM_REGS,
    parameter int ADDR_WIDTH      = $clog2(NUM_REGS),
    parameter int REG_ZERO_GROUND = 1,
    parameter int NUM_READ        = DEF_NUM_READ,
    parameter int NUM_WRITE       = DEF_NUM_WRITE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WRITE-1:0]            write_enable,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_WRITE*REG_WIDTH-1:0]  write_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  read_addr,
    output logic [NUM_READ*REG_WIDTH-1:0]   read_data,
    output logic [NUM_READ-1:0]             read_busy,
    input  logic                            reserve_valid,
    input  logic [ADDR_WIDTH-1:0]           reserve_addr,
    output logic [ADDR_WIDTH:0]             busy_count
);

    logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  w_we;
    logic [REG_WIDTH-1:0] w_wd   [NUM_REGS];
    logic [NUM_REGS-1:0]  w_busy;
    logic                 w_reserve;

    // Per-register write decode; scanning ports upward lets the highest port win.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_we[r] = 1'b0;
            w_wd[r] = '0;
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (write_enable[p] &&
                    write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    w_we[r] = 1'b1;
                    w_wd[r] = write_data[p*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
        w_reserve = reserve_valid;
        if (REG_ZERO_GROUND != 0) begin
            w_we[0] = 1'b0;
            if (reserve_addr == '0) begin
                w_reserve = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_we[r]) begin
                    r_regs[r] <= w_wd[r];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set_en     (w_reserve),
        .i_set_addr   (reserve_addr),
        .i_clr_vec    (w_we),
        .o_busy       (w_busy),
        .o_busy_count (busy_count)
    );

    // Storage and busy bits are cleared asynchronously, so reads during reset are
    // already 0; only the bypass path needs an explicit reset gate.
    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            read_data[i*REG_WIDTH +: REG_WIDTH] = r_regs[read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            read_busy[i]                        = w_busy[read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
            // w_we[0] is already forced low when register 0 is grounded.
            if (rst_n && w_we[read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]) begin
                read_data[i*REG_WIDTH +: REG_WIDTH] = w_wd[read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                read_busy[i]                        = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport
module tb_regfile_multiport;
    import regfile_pkg::*;

    localparam int RW = 32, NR = 32, AW = 5, NRD = 4, NWR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NWR-1:0]    write_enable;
    logic [NWR*AW-1:0] write_addr;
    logic [NWR*RW-1:0] write_data;
    logic [NRD*AW-1:0] read_addr;
    logic [NRD*RW-1:0] read_data;
    logic [NRD-1:0]    read_busy;
    logic              reserve_valid;
    logic [AW-1:0]     reserve_addr;
    logic [AW:0]       busy_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    wr_req_t       wr [NWR];
    logic [RW-1:0] exp_data_q [$];
    logic          exp_busy_q [$];

    regfile_multiport dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .read_busy     (read_busy),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .busy_count    (busy_count)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] rd(input int i);
        return read_data[i*RW +: RW];
    endfunction

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [RW-1:0] d);
        wr[p].en = en; wr[p].addr = a; wr[p].data = d;
        write_enable[p] = en;
        write_addr[p*AW +: AW] = a;
        write_data[p*RW +: RW] = d;
    endtask

    task automatic set_ra(input int i, input logic [AW-1:0] a);
        read_addr[i*AW +: AW] = a;
    endtask

    task automatic idle();
        for (int p = 0; p < NWR; p++) set_wr(p, 1'b0, '0, '0);
        reserve_valid = 1'b0;
        reserve_addr  = '0;
    endtask

    function automatic logic [RW-1:0] model_read(input logic [AW-1:0] a);
        logic [RW-1:0] v;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (wr[p].en && wr[p].addr == a && a != 0) v = wr[p].data;
`endif
        if (!rst_n) v = '0;
        return v;
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        logic b;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (wr[p].en && wr[p].addr == a && a != 0) b = 1'b0;
`endif
        if (!rst_n) b = 1'b0;
        return b;
    endfunction

    // Reference commit at the coming edge, then sample 1ns after it.
    task automatic cycle();
        logic [NR-1:0] clr;
        if (rst_n) begin
            clr = '0;
            for (int p = 0; p < NWR; p++)
                if (wr[p].en && wr[p].addr != 0) begin
                    m_regs[wr[p].addr] = wr[p].data;
                    clr[wr[p].addr] = 1'b1;
                end
            m_busy = m_busy & ~clr;
            if (reserve_valid && reserve_addr != 0) m_busy[reserve_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_busy = '0;
    endtask

    task automatic test_reset();
        logic [RW-1:0] d;
        rst_n = 1'b1; idle(); read_addr = '0; model_clear();
        #2 rst_n = 1'b0;
        for (int i = 0; i < NRD; i++) set_ra(i, AW'(i + 1));
        @(posedge clk); #1;
        for (int i = 0; i < NRD; i++) begin
            exp_data_q.push_back('0);
            d = exp_data_q.pop_front();
            n_checks++;
            if (rd(i) !== d || read_busy[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_read port%0d: got %h/%b want %h/0", i, rd(i), read_busy[i], d);
            end
        end
        n_checks++;
        if (busy_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", busy_count); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        set_wr(0, 1'b1, 5'd1, 32'hDEADBEEF);
        exp_data_q.push_back(32'hDEADBEEF);
        cycle(); idle(); set_ra(0, 5'd1); #1;
        n_checks++;
        if (rd(0) !== exp_data_q[0] || read_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL write_read: got %h/%b want %h/0", rd(0), read_busy[0], exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
    endtask

    task automatic test_priority();
        logic [RW-1:0] d;
        set_wr(0, 1'b1, 5'd5, 32'h11111111);
        set_wr(1, 1'b1, 5'd5, 32'h22222222);
        exp_data_q.push_back(32'h22222222);
        cycle(); idle(); set_ra(1, 5'd5); #1;
        d = exp_data_q.pop_front();
        n_checks++;
        if (rd(1) !== d) begin n_fail++; $display("FAIL port_priority: got %h want %h", rd(1), d); end
    endtask

    task automatic test_zero();
        logic [RW-1:0] d;
        set_wr(0, 1'b1, 5'd0, 32'h12345678);
        reserve_valid = 1'b1; reserve_addr = 5'd0;
        set_ra(2, 5'd0); #1;
        exp_data_q.push_back('0);
        d = exp_data_q.pop_front();
        n_checks++;
        if (rd(2) !== d || read_busy[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_sameclk: got %h/%b want 0/0", rd(2), read_busy[2]);
        end
        cycle(); idle(); #1;
        n_checks++;
        if (rd(2) !== '0 || read_busy[2] !== 1'b0 || busy_count !== '0) begin
            n_fail++; $display("FAIL zero_reg: got %h/%b cnt %0d want 0/0 cnt 0", rd(2), read_busy[2], busy_count);
        end
    endtask

    task automatic test_scoreboard();
        reserve_valid = 1'b1; reserve_addr = 5'd7; cycle();
        reserve_addr = 5'd9; cycle(); idle();
        set_ra(0, 5'd7); set_ra(1, 5'd9); #1;
        n_checks++;
        if (busy_count !== 6'd2 || read_busy[1:0] !== 2'b11) begin
            n_fail++; $display("FAIL reserve_two: got cnt %0d busy %b want cnt 2 busy 11", busy_count, read_busy[1:0]);
        end
        set_wr(0, 1'b1, 5'd7, 32'hAABBCCDD);
        exp_data_q.push_back(32'hAABBCCDD);
        cycle(); idle(); #1;
        n_checks++;
        if (busy_count !== 6'd1 || read_busy[1:0] !== 2'b10 || rd(0) !== exp_data_q[0]) begin
            n_fail++; $display("FAIL write_clears: got cnt %0d busy %b data %h want cnt 1 busy 10 data %h",
                               busy_count, read_busy[1:0], rd(0), exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
        reserve_valid = 1'b1; reserve_addr = 5'd9; cycle(); idle(); #1;
        n_checks++;
        if (busy_count !== 6'd1 || read_busy[1] !== 1'b1) begin
            n_fail++; $display("FAIL rereserve: got cnt %0d busy %b want cnt 1 busy 1", busy_count, read_busy[1]);
        end
    endtask

    task automatic test_reserve_write();
        logic [RW-1:0] d;
        reserve_valid = 1'b1; reserve_addr = 5'd3;
        set_wr(1, 1'b1, 5'd3, 32'h33333333);
        set_wr(0, 1'b1, 5'd4, 32'h44444444);
        cycle(); idle(); set_ra(2, 5'd3); #1;
        n_checks++;
        if (read_busy[2] !== 1'b1 || rd(2) !== 32'h33333333 || busy_count !== 6'd2) begin
            n_fail++; $display("FAIL reserve_and_write: got %h/%b cnt %0d want 33333333/1 cnt 2", rd(2), read_busy[2], busy_count);
        end
        set_wr(0, 1'b1, 5'd4, 32'hCAFEF00D);
        set_ra(3, 5'd4); #1;
`ifdef REGFILE_BYPASS_EN
        exp_data_q.push_back(32'hCAFEF00D);
`else
        exp_data_q.push_back(32'h44444444);
`endif
        d = exp_data_q.pop_front();
        n_checks++;
        if (rd(3) !== d) begin n_fail++; $display("FAIL sameclk_read: got %h want %h", rd(3), d); end
        cycle(); idle(); #1;
        n_checks++;
        if (rd(3) !== 32'hCAFEF00D) begin n_fail++; $display("FAIL next_read: got %h want cafef00d", rd(3)); end
    endtask

    task automatic test_random();
        logic [RW-1:0] d;
        logic          b;
        logic [AW:0]   c;
        for (int n = 0; n < 80; n++) begin
            for (int p = 0; p < NWR; p++)
                set_wr(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            reserve_valid = ($urandom_range(0, 2) == 0);
            reserve_addr  = AW'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) set_ra(i, AW'($urandom_range(0, 7)));
            #1;
            for (int i = 0; i < NRD; i++) begin
                exp_data_q.push_back(model_read(read_addr[i*AW +: AW]));
                exp_busy_q.push_back(model_busy(read_addr[i*AW +: AW]));
            end
            for (int i = 0; i < NRD; i++) begin
                d = exp_data_q.pop_front();
                b = exp_busy_q.pop_front();
                n_checks++;
                if (rd(i) !== d || read_busy[i] !== b) begin
                    n_fail++; $display("FAIL random_read it%0d port%0d: got %h/%b want %h/%b", n, i, rd(i), read_busy[i], d, b);
                end
            end
            c = (AW+1)'($countones(m_busy));
            n_checks++;
            if (busy_count !== c) begin n_fail++; $display("FAIL random_count it%0d: got %0d want %0d", n, busy_count, c); end
            cycle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int a = 1; a < NR; a += 2) begin
            set_wr(0, 1'b1, AW'(a), 32'h1000 + a);
            set_wr(1, 1'b1, AW'(a + 1), 32'h1000 + a + 1);
            cycle();
        end
        idle();
        reserve_valid = 1'b1; reserve_addr = 5'd10; cycle();
        set_wr(0, 1'b1, 5'd31, 32'hBAD0BAD0);
        reserve_addr = 5'd11;
        set_ra(0, 5'd10); set_ra(1, 5'd31); set_ra(2, 5'd1); set_ra(3, 5'd15);
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        for (int i = 0; i < NRD; i++) begin
            n_checks++;
            if (rd(i) !== '0 || read_busy[i] !== 1'b0) begin
                n_fail++; $display("FAIL midreset_read port%0d: got %h/%b want 0/0", i, rd(i), read_busy[i]);
            end
        end
        n_checks++;
        if (busy_count !== '0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", busy_count); end
        cycle();
        idle(); rst_n = 1'b1;
        cycle();
        n_checks++;
        if (rd(1) !== '0 || busy_count !== '0) begin
            n_fail++; $display("FAIL post_reset: got %h cnt %0d want 0 cnt 0", rd(1), busy_count);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_zero();
        test_scoreboard();
        test_reserve_write();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
